mac_operand_sequencer: RTL and testbench

- Drives the MAC datapath: streams weight/input operand pairs into the multiply–accumulate chain.
- Frames each dot-product row with start_accumulate.
- Holds a local input vector buffer and a weight matrix buffer, both written by the host before a run.
- Strobes the host when each row's accumulated ai is stable at the MAC output, so the tanh stage can capture it.

---
 rtl/mac_operand_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the MAC chain: streams weight/input pairs row by row from
// host-loaded buffers and strobes ai_capture when each row's sum is stable at the MAC output.
module mac_operand_sequencer #(
    parameter  int DATA_W   = 16,
    parameter  int VEC_LEN  = 8,
    parameter  int ROWS     = 4,
    parameter  int PIPE_LAT = 3,
    localparam int XA_W     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int RA_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int WA_W     = (ROWS * VEC_LEN > 1) ? $clog2(ROWS * VEC_LEN) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_wr_en,
    input  logic [XA_W-1:0]   x_wr_addr,
    input  logic [DATA_W-1:0] x_wr_data,
    input  logic              w_wr_en,
    input  logic [WA_W-1:0]   w_wr_addr,
    input  logic [DATA_W-1:0] w_wr_data,
    input  logic              start,
    output logic [DATA_W-1:0] Weightg,
    output logic [DATA_W-1:0] Xt,
    output logic              start_accumulate,
    output logic              ai_capture,
    output logic [RA_W-1:0]   ai_row,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;
    localparam int         WC_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    logic [DATA_W-1:0] x_buf_q [VEC_LEN];
    logic [DATA_W-1:0] w_buf_q [ROWS*VEC_LEN];

    logic [1:0]        state_q, state_d;
    logic [XA_W-1:0]   col_q, col_d;
    logic [RA_W-1:0]   row_q, row_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0] weight_q, weight_d;
    logic [DATA_W-1:0] xt_q, xt_d;
    logic              sa_q, sa_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cap_in_d;
    logic [RA_W-1:0]   cap_row_in_d;
    logic [PIPE_LAT-1:0] cap_vld_q;
    logic [RA_W-1:0]   cap_row_q [PIPE_LAT];
    logic              ai_capture_q;
    logic [RA_W-1:0]   ai_row_q;

    logic              x_wr_ok_s, w_wr_ok_s;
    logic [WA_W-1:0]   w_idx_s;
    logic [DATA_W-1:0] x_rd_s, w_rd_s;

    // Buffers only change while idle, so a run always sees a frozen operand set.
    assign x_wr_ok_s = x_wr_en && (state_q == S_IDLE);
    assign w_wr_ok_s = w_wr_en && (state_q == S_IDLE);

    // Host buffer writes; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (x_wr_ok_s) begin
            x_buf_q[x_wr_addr] <= x_wr_data;
        end
        if (w_wr_ok_s) begin
            w_buf_q[w_wr_addr] <= w_wr_data;
        end
    end

    // Next-state: row/column walk through STREAM, then FLUSH and the pipeline drain.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    col_d   = {XA_W{1'b0}};
                    row_d   = {RA_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (col_q == XA_W'(VEC_LEN - 1)) begin
                    col_d = {XA_W{1'b0}};
                    if (row_q == RA_W'(ROWS - 1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        row_d = row_q + RA_W'(1);
                    end
                end else begin
                    col_d = col_q + XA_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_WAIT;
                wcnt_d  = {WC_W{1'b0}};
            end
            S_WAIT: begin
                if (wcnt_q == WC_W'(PIPE_LAT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand reads bypass a write landing in the same cycle as start.
    assign w_idx_s = WA_W'(int'(row_d) * VEC_LEN + int'(col_d));

    // Buffer read with same-cycle write forwarding.
    always_comb begin
        if (x_wr_ok_s && (x_wr_addr == col_d)) begin
            x_rd_s = x_wr_data;
        end else begin
            x_rd_s = x_buf_q[col_d];
        end
        if (w_wr_ok_s && (w_wr_addr == w_idx_s)) begin
            w_rd_s = w_wr_data;
        end else begin
            w_rd_s = w_buf_q[w_idx_s];
        end
    end

    // Output values for the upcoming cycle; a row's capture is queued when the next row opens.
    always_comb begin
        weight_d     = {DATA_W{1'b0}};
        xt_d         = {DATA_W{1'b0}};
        sa_d         = 1'b0;
        cap_in_d     = 1'b0;
        cap_row_in_d = {RA_W{1'b0}};
        if (state_d == S_STREAM) begin
            weight_d = w_rd_s;
            xt_d     = x_rd_s;
            sa_d     = (col_d == {XA_W{1'b0}});
            if ((col_d == {XA_W{1'b0}}) && (row_d != {RA_W{1'b0}})) begin
                cap_in_d     = 1'b1;
                cap_row_in_d = row_d - RA_W'(1);
            end else begin
                cap_in_d     = 1'b0;
            end
        end else if (state_d == S_FLUSH) begin
            sa_d         = 1'b1;
            cap_in_d     = 1'b1;
            cap_row_in_d = RA_W'(ROWS - 1);
        end else begin
            sa_d         = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_WAIT) && (wcnt_d == WC_W'(PIPE_LAT - 1));
    end

    // State, registered outputs and the capture delay line mirroring MAC latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= {XA_W{1'b0}};
            row_q        <= {RA_W{1'b0}};
            wcnt_q       <= {WC_W{1'b0}};
            weight_q     <= {DATA_W{1'b0}};
            xt_q         <= {DATA_W{1'b0}};
            sa_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cap_vld_q    <= {PIPE_LAT{1'b0}};
            for (int k = 0; k < PIPE_LAT; k++) begin
                cap_row_q[k] <= {RA_W{1'b0}};
            end
            ai_capture_q <= 1'b0;
            ai_row_q     <= {RA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wcnt_q       <= wcnt_d;
            weight_q     <= weight_d;
            xt_q         <= xt_d;
            sa_q         <= sa_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cap_vld_q[0] <= cap_in_d;
            cap_row_q[0] <= cap_row_in_d;
            for (int k = 1; k < PIPE_LAT; k++) begin
                cap_vld_q[k] <= cap_vld_q[k-1];
                cap_row_q[k] <= cap_row_q[k-1];
            end
            ai_capture_q <= cap_vld_q[PIPE_LAT-1];
            ai_row_q     <= cap_row_q[PIPE_LAT-1];
        end
    end

    assign Weightg          = weight_q;
    assign Xt               = xt_q;
    assign start_accumulate = sa_q;
    assign ai_capture       = ai_capture_q;
    assign ai_row           = ai_row_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed self-checking bench for mac_operand_sequencer: default instance plus a
// VEC_LEN=1/ROWS=1 instance; cycle 0 is the cycle in which start is driven.
module tb_mac_operand_sequencer;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        x_wr_en = 1'b0;
    logic [2:0]  x_wr_addr = 3'd0;
    logic [15:0] x_wr_data = 16'd0;
    logic        w_wr_en = 1'b0;
    logic [4:0]  w_wr_addr = 5'd0;
    logic [15:0] w_wr_data = 16'd0;
    logic        start = 1'b0;
    logic [15:0] Weightg, Xt;
    logic        start_accumulate, ai_capture, busy, done;
    logic [1:0]  ai_row;

    logic        c_x_wr_en = 1'b0;
    logic [0:0]  c_x_wr_addr = 1'b0;
    logic [15:0] c_x_wr_data = 16'd0;
    logic        c_w_wr_en = 1'b0;
    logic [0:0]  c_w_wr_addr = 1'b0;
    logic [15:0] c_w_wr_data = 16'd0;
    logic        c_start = 1'b0;
    logic [15:0] c_Weightg, c_Xt;
    logic        c_sa, c_cap, c_busy, c_done;
    logic [0:0]  c_ai_row;

    int checks = 0;
    int failures = 0;

    logic [15:0] r_wg [48];
    logic [15:0] r_xt [48];
    logic        r_sa [48];
    logic        r_cap [48];
    logic [1:0]  r_row [48];
    logic        r_busy [48];
    logic        r_done [48];

    mac_operand_sequencer u_dut (
        .clock(clock), .reset(reset),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .start(start), .Weightg(Weightg), .Xt(Xt),
        .start_accumulate(start_accumulate), .ai_capture(ai_capture), .ai_row(ai_row),
        .busy(busy), .done(done)
    );

    mac_operand_sequencer #(.VEC_LEN(1), .ROWS(1)) u_dut_c (
        .clock(clock), .reset(reset),
        .x_wr_en(c_x_wr_en), .x_wr_addr(c_x_wr_addr), .x_wr_data(c_x_wr_data),
        .w_wr_en(c_w_wr_en), .w_wr_addr(c_w_wr_addr), .w_wr_data(c_w_wr_data),
        .start(c_start), .Weightg(c_Weightg), .Xt(c_Xt),
        .start_accumulate(c_sa), .ai_capture(c_cap), .ai_row(c_ai_row),
        .busy(c_busy), .done(c_done)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_x(input int a, input logic [15:0] v);
        x_wr_en = 1'b1; x_wr_addr = 3'(a); x_wr_data = v;
        step();
        x_wr_en = 1'b0;
    endtask

    task automatic write_w(input int a, input logic [15:0] v);
        w_wr_en = 1'b1; w_wr_addr = 5'(a); w_wr_data = v;
        step();
        w_wr_en = 1'b0;
    endtask

    // kind: 1 write x[0]=FFFF plus start, 2 reset, 3 write x[0]=0040, 4 start only
    task automatic run_capture(input int n, input int inj_cyc, input int inj_kind);
        for (int c = 0; c < n; c++) begin
            start = (c == 0);
            if (c == inj_cyc) begin
                case (inj_kind)
                    1: begin x_wr_en = 1'b1; x_wr_addr = 3'd0; x_wr_data = 16'hFFFF; start = 1'b1; end
                    2: reset = 1'b1;
                    3: begin x_wr_en = 1'b1; x_wr_addr = 3'd0; x_wr_data = 16'h0040; end
                    4: start = 1'b1;
                    default: ;
                endcase
            end
            r_wg[c] = Weightg; r_xt[c] = Xt; r_sa[c] = start_accumulate;
            r_cap[c] = ai_capture; r_row[c] = ai_row; r_busy[c] = busy; r_done[c] = done;
            step();
            start = 1'b0; x_wr_en = 1'b0; reset = 1'b0;
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (Weightg !== 16'd0) begin failures++; $display("FAIL reset_wg got=%h exp=0", Weightg); end
        checks++; if (Xt !== 16'd0) begin failures++; $display("FAIL reset_xt got=%h exp=0", Xt); end
        checks++; if (start_accumulate !== 1'b0) begin failures++; $display("FAIL reset_sa got=%b exp=0", start_accumulate); end
        checks++; if (ai_capture !== 1'b0) begin failures++; $display("FAIL reset_cap got=%b exp=0", ai_capture); end
        checks++; if (ai_row !== 2'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", ai_row); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] exp_xt, exp_wg;
        logic exp_sa, exp_cap, exp_busy, exp_done;
        for (int i = 0; i < 8; i++) write_x(i, 16'(i + 1));
        for (int n = 0; n < 32; n++) write_w(n, 16'h0008);
        run_capture(40, -1, 0);
        for (int c = 0; c < 40; c++) begin
            exp_sa   = (c >= 1) && (c <= 33) && ((c - 1) % 8 == 0);
            exp_cap  = (c >= 12) && (c <= 36) && ((c - 12) % 8 == 0);
            exp_done = (c == 36);
            exp_busy = (c >= 1) && (c <= 36);
            exp_xt   = ((c >= 1) && (c <= 32)) ? 16'((c - 1) % 8 + 1) : 16'd0;
            exp_wg   = ((c >= 1) && (c <= 32)) ? 16'h0008 : 16'd0;
            checks++; if (r_sa[c] !== exp_sa) begin failures++; $display("FAIL basic_sa c=%0d got=%b exp=%b", c, r_sa[c], exp_sa); end
            checks++; if (r_cap[c] !== exp_cap) begin failures++; $display("FAIL basic_cap c=%0d got=%b exp=%b", c, r_cap[c], exp_cap); end
            checks++; if (r_done[c] !== exp_done) begin failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, r_done[c], exp_done); end
            checks++; if (r_busy[c] !== exp_busy) begin failures++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, r_busy[c], exp_busy); end
            checks++; if (r_xt[c] !== exp_xt) begin failures++; $display("FAIL basic_xt c=%0d got=%h exp=%h", c, r_xt[c], exp_xt); end
            checks++; if (r_wg[c] !== exp_wg) begin failures++; $display("FAIL basic_wg c=%0d got=%h exp=%h", c, r_wg[c], exp_wg); end
            if (exp_cap) begin
                checks++; if (r_row[c] !== 2'((c - 12) / 8)) begin failures++; $display("FAIL basic_row c=%0d got=%0d exp=%0d", c, r_row[c], (c - 12) / 8); end
            end
        end
    endtask

    task automatic test_ordering();
        for (int n = 0; n < 32; n++) write_w(n, 16'(n << 3));
        run_capture(40, -1, 0);
        for (int n = 0; n < 32; n++) begin
            checks++; if (r_wg[1+n] !== 16'(n << 3)) begin failures++; $display("FAIL order_wg n=%0d got=%h exp=%h", n, r_wg[1+n], 16'(n << 3)); end
            checks++; if (r_xt[1+n] !== 16'(n % 8 + 1)) begin failures++; $display("FAIL order_xt n=%0d got=%h exp=%h", n, r_xt[1+n], 16'(n % 8 + 1)); end
        end
        for (int c = 33; c <= 36; c++) begin
            checks++; if ((r_wg[c] !== 16'd0) || (r_xt[c] !== 16'd0)) begin failures++; $display("FAIL order_flush_zero c=%0d got=%h/%h exp=0/0", c, r_wg[c], r_xt[c]); end
        end
    endtask

    task automatic test_busy_ignore();
        run_capture(40, 5, 1);
        for (int c = 1; c <= 32; c++) begin
            checks++; if (r_xt[c] !== 16'((c - 1) % 8 + 1)) begin failures++; $display("FAIL busy_xt c=%0d got=%h exp=%h", c, r_xt[c], 16'((c - 1) % 8 + 1)); end
            checks++; if (r_wg[c] !== 16'((c - 1) << 3)) begin failures++; $display("FAIL busy_wg c=%0d got=%h exp=%h", c, r_wg[c], 16'((c - 1) << 3)); end
        end
        for (int c = 0; c < 40; c++) begin
            checks++; if (r_done[c] !== (c == 36)) begin failures++; $display("FAIL busy_done c=%0d got=%b exp=%b", c, r_done[c], (c == 36)); end
        end
        run_capture(40, -1, 0);
        checks++; if (r_xt[1] !== 16'h0001) begin failures++; $display("FAIL busy_next_run_x0 got=%h exp=0001", r_xt[1]); end
        checks++; if (r_done[36] !== 1'b1) begin failures++; $display("FAIL busy_next_run_done got=%b exp=1", r_done[36]); end
    endtask

    task automatic test_reset_mid();
        run_capture(40, 15, 2);
        checks++; if (r_cap[12] !== 1'b1) begin failures++; $display("FAIL rstmid_cap12 got=%b exp=1", r_cap[12]); end
        checks++; if ((r_wg[16] !== 16'd0) || (r_xt[16] !== 16'd0) || (r_sa[16] !== 1'b0) || (r_row[16] !== 2'd0))
            begin failures++; $display("FAIL rstmid_outs16 got=%h/%h/%b/%0d exp=0/0/0/0", r_wg[16], r_xt[16], r_sa[16], r_row[16]); end
        for (int c = 16; c < 40; c++) begin
            checks++; if ((r_cap[c] !== 1'b0) || (r_done[c] !== 1'b0) || (r_busy[c] !== 1'b0))
                begin failures++; $display("FAIL rstmid_quiet c=%0d got=cap%b done%b busy%b exp=000", c, r_cap[c], r_done[c], r_busy[c]); end
        end
        run_capture(40, -1, 0);
        checks++; if (r_xt[1] !== 16'h0001) begin failures++; $display("FAIL rstmid_buf_kept got=%h exp=0001", r_xt[1]); end
        checks++; if ((r_done[36] !== 1'b1) || (r_cap[36] !== 1'b1) || (r_row[36] !== 2'd3))
            begin failures++; $display("FAIL rstmid_rerun got=done%b cap%b row%0d exp=1 1 3", r_done[36], r_cap[36], r_row[36]); end
    endtask

    task automatic test_same_cycle();
        run_capture(40, 0, 3);
        for (int r = 0; r < 4; r++) begin
            checks++; if (r_xt[1+8*r] !== 16'h0040) begin failures++; $display("FAIL same_xt c=%0d got=%h exp=0040", 1 + 8 * r, r_xt[1+8*r]); end
        end
        checks++; if (r_xt[2] !== 16'h0002) begin failures++; $display("FAIL same_xt2 got=%h exp=0002", r_xt[2]); end
    endtask

    task automatic test_back_to_back();
        run_capture(40, 36, 4);
        checks++; if (r_done[36] !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", r_done[36]); end
        for (int c = 37; c < 40; c++) begin
            checks++; if ((r_busy[c] !== 1'b0) || (r_sa[c] !== 1'b0)) begin failures++; $display("FAIL b2b_idle c=%0d got=busy%b sa%b exp=00", c, r_busy[c], r_sa[c]); end
        end
    endtask

    task automatic test_corner();
        c_x_wr_en = 1'b1; c_x_wr_data = 16'h0003; c_w_wr_en = 1'b1; c_w_wr_data = 16'h0005;
        step();
        c_x_wr_en = 1'b0; c_w_wr_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            c_start = (c == 0);
            checks++; if (c_sa !== ((c == 1) || (c == 2))) begin failures++; $display("FAIL corner_sa c=%0d got=%b exp=%b", c, c_sa, ((c == 1) || (c == 2))); end
            checks++; if (c_cap !== (c == 5)) begin failures++; $display("FAIL corner_cap c=%0d got=%b exp=%b", c, c_cap, (c == 5)); end
            checks++; if (c_done !== (c == 5)) begin failures++; $display("FAIL corner_done c=%0d got=%b exp=%b", c, c_done, (c == 5)); end
            if (c == 1) begin
                checks++; if ((c_Weightg !== 16'h0005) || (c_Xt !== 16'h0003)) begin failures++; $display("FAIL corner_ops got=%h/%h exp=0005/0003", c_Weightg, c_Xt); end
            end
            if (c == 5) begin
                checks++; if (c_ai_row !== 1'b0) begin failures++; $display("FAIL corner_row got=%0d exp=0", c_ai_row); end
            end
            step();
            c_start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ordering();
        test_busy_ignore();
        test_reset_mid();
        test_same_cycle();
        test_back_to_back();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
